// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        STT_IDLE  = 3'd0,
        STT_START = 3'd1,
        STT_DATA  = 3'd2,
        STT_STOP  = 3'd3,
        STT_BREAK = 3'd4
    } statetype;

    // Number of clk cycles per serial bit.
    function automatic int pulse_width(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous level; flops reset to 1 (idle line level).
module uart_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    if (N < 2) begin : g_bad_n
        $error("uart_sync: N must be at least 2");
    end

    logic [N-1:0] sync_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[N-2:0], d};
        end
    end

    assign q = sync_reg[N-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing, mid-bit sampling, one-entry valid/ready output buffer
// with frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 9600,
    parameter int CLK_FREQ   = 12_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  sig,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  frame_err,
    output logic                  overrun_err
);

    localparam int PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int LB_DATA_WIDTH    = $clog2(DATA_WIDTH);
    localparam int LB_PULSE_WIDTH   = $clog2(PULSE_WIDTH);
    localparam int CNT_W            = LB_PULSE_WIDTH + 1;

    localparam logic [CNT_W-1:0]         HALF_LOAD  = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0]         PULSE_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0]         CNT_ONE    = CNT_W'(1);
    localparam logic [LB_DATA_WIDTH-1:0] LAST_BIT   = LB_DATA_WIDTH'(DATA_WIDTH - 1);
    localparam logic [LB_DATA_WIDTH-1:0] BIT_ONE    = LB_DATA_WIDTH'(1);

    if (PULSE_WIDTH < 4) begin : g_bad_pulse_width
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    logic s;

    uart_sync #(.N(2)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (sig),
        .q    (s)
    );

    statetype                 state_reg, state_next;
    logic [CNT_W-1:0]         clk_cnt_reg, clk_cnt_next;
    logic [LB_DATA_WIDTH-1:0] bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0]    shreg_reg, shreg_next;
    logic                     deliver_reg, deliver_next;
    logic                     frame_err_reg, frame_err_next;
    logic [DATA_WIDTH-1:0]    data_reg, data_next;
    logic                     valid_reg, valid_next;
    logic                     overrun_reg, overrun_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= STT_IDLE;
            clk_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shreg_reg     <= '0;
            deliver_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clk_cnt_reg   <= clk_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shreg_reg     <= shreg_next;
            deliver_reg   <= deliver_next;
            frame_err_reg <= frame_err_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Frame sequencing: every sampling state counts clk_cnt down to 0, then acts on s.
    always_comb begin
        state_next     = state_reg;
        clk_cnt_next   = clk_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shreg_next     = shreg_reg;
        deliver_next   = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            STT_IDLE: begin
                if (!s) begin
                    clk_cnt_next = HALF_LOAD;
                    state_next   = STT_START;
                end
            end
            STT_START: begin
                if (clk_cnt_reg != '0) begin
                    clk_cnt_next = clk_cnt_reg - CNT_ONE;
                end else if (!s) begin
                    clk_cnt_next = PULSE_LOAD;
                    bit_cnt_next = '0;
                    state_next   = STT_DATA;
                end else begin
                    state_next   = STT_IDLE;
                end
            end
            STT_DATA: begin
                if (clk_cnt_reg != '0) begin
                    clk_cnt_next = clk_cnt_reg - CNT_ONE;
                end else begin
                    shreg_next[bit_cnt_reg] = s;
                    clk_cnt_next            = PULSE_LOAD;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = STT_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BIT_ONE;
                    end
                end
            end
            STT_STOP: begin
                if (clk_cnt_reg != '0) begin
                    clk_cnt_next = clk_cnt_reg - CNT_ONE;
                end else if (s) begin
                    deliver_next = 1'b1;
                    state_next   = STT_IDLE;
                end else begin
                    frame_err_next = 1'b1;
                    state_next     = STT_BREAK;
                end
            end
            STT_BREAK: begin
                // A held-low line must go high before a new start can be recognised.
                if (s) begin
                    state_next = STT_IDLE;
                end
            end
            default: begin
                state_next = STT_IDLE;
            end
        endcase
    end

    // Output buffer: a delivery overwrites only an empty or simultaneously consumed word.
    always_comb begin
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_next = 1'b0;

        if (deliver_reg) begin
            if (!valid_reg || ready) begin
                data_next  = shreg_reg;
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (valid_reg && ready) begin
            valid_next = 1'b0;
        end
    end

    assign data        = data_reg;
    assign valid       = valid_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a word-level reference model of the receiver.
module tb_uart_rx;
    import uart_pkg::*;

    timeunit 1ns;
    timeprecision 1ps;

    localparam int DW   = 8;
    localparam int CF   = 160;
    localparam int BR   = 10;
    localparam int PW   = CF / BR;
    localparam int HALF = PW / 2;
    // Pin edge to observed valid: two synchroniser edges, the start-detect edge,
    // the sampling schedule up to the stop bit, and the delivery edge.
    localparam int LAT  = 3 + HALF + (DW + 1) * PW + 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          sig;
    logic          ready;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          overrun_err;

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(BR), .CLK_FREQ(CF)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .sig         (sig),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int            rise_cnt = 0;
    int            ferr_cnt = 0;
    int            ovr_cnt  = 0;
    time           last_rise = 0;
    time           t_start   = 0;
    logic          valid_d   = 1'b0;

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid && ready) got_q.push_back(data);
        if (valid && !valid_d) begin
            rise_cnt++;
            last_rise = $time;
        end
        valid_d = valid;
        if (frame_err) ferr_cnt++;
        if (overrun_err) ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Called on a falling edge; leaves sig at the stop-bit level.
    task automatic send_frame(input logic [DW-1:0] b, input logic stop_bit);
        sig     = 1'b0;
        t_start = $time;
        repeat (PW) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            sig = b[i];
            repeat (PW) @(negedge clk);
        end
        sig = stop_bit;
        repeat (PW) @(negedge clk);
    endtask

    initial begin
        int            rises_exp;
        int            ferr_exp;
        int            ovr_exp;
        int            glitch;
        int            gap;
        logic [DW-1:0] b;
        logic [DW-1:0] seq[3];

        rises_exp = 0;
        ferr_exp  = 0;
        ovr_exp   = 0;
        rstn  = 1'b0;
        sig   = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun_err), 32'd0);
        chk("rst_state", 32'(dut.state_reg), 32'(STT_IDLE));
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Clean frame and latency.
        send_frame(8'hA5, 1'b1);
        sig = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back(8'hA5);
        rises_exp++;
        chk("a5_rises", 32'(rise_cnt), 32'(rises_exp));
        chk("a5_latency", 32'((last_rise - t_start) / 10), 32'(LAT));
        chk("a5_hold", 32'(data), 32'hA5);
        chk("a5_errs", 32'(ferr_cnt + ovr_cnt), 32'd0);

        // Short low glitch is a false start.
        glitch = $urandom_range(1, 5);
        sig = 1'b0;
        repeat (glitch) @(negedge clk);
        sig = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_state", 32'(dut.state_reg), 32'(STT_IDLE));
        chk("glitch_rises", 32'(rise_cnt), 32'(rises_exp));
        chk("glitch_errs", 32'(ferr_cnt + ovr_cnt), 32'd0);

        // Stop bit low, then a long break.
        send_frame(8'h3C, 1'b0);
        repeat (100) @(negedge clk);
        ferr_exp++;
        chk("ferr_count", 32'(ferr_cnt), 32'(ferr_exp));
        chk("ferr_rises", 32'(rise_cnt), 32'(rises_exp));
        sig = 1'b1;
        repeat (20) @(negedge clk);
        chk("break_ferr", 32'(ferr_cnt), 32'(ferr_exp));
        chk("break_state", 32'(dut.state_reg), 32'(STT_IDLE));
        send_frame(8'h5A, 1'b1);
        sig = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h5A);
        rises_exp++;
        chk("after_brk_data", 32'(data), 32'h5A);

        // Overrun: consumer stalled over two back-to-back frames.
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        sig = 1'b1;
        repeat (10) @(negedge clk);
        rises_exp++;
        ovr_exp++;
        chk("ovr_valid", 32'(valid), 32'd1);
        chk("ovr_data", 32'(data), 32'h11);
        chk("ovr_count", 32'(ovr_cnt), 32'(ovr_exp));
        chk("ovr_rises", 32'(rise_cnt), 32'(rises_exp));
        @(posedge clk);
        #1 ready = 1'b1;
        @(negedge clk);
        chk("ovr_pending", 32'(valid), 32'd1);
        exp_q.push_back(8'h11);
        @(negedge clk);
        chk("ovr_drop", 32'(valid), 32'd0);

        // Three frames with no idle gap.
        seq[0] = 8'h00;
        seq[1] = 8'hFF;
        seq[2] = 8'h81;
        for (int i = 0; i < 3; i++) begin
            send_frame(seq[i], 1'b1);
            exp_q.push_back(seq[i]);
            rises_exp++;
        end
        sig = 1'b1;
        repeat (10) @(negedge clk);
        chk("b2b_rises", 32'(rise_cnt), 32'(rises_exp));

        // Reset in the middle of bit 4.
        b = 8'h77;
        sig = 1'b0;
        repeat (PW) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sig = b[i];
            repeat (PW) @(negedge clk);
        end
        sig = b[4];
        repeat (PW / 2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_state", 32'(dut.state_reg), 32'(STT_IDLE));
        sig = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_rises", 32'(rise_cnt), 32'(rises_exp));
        send_frame(8'h77, 1'b1);
        sig = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back(8'h77);
        rises_exp++;
        chk("post_rst_data", 32'(data), 32'h77);

        // Random words with random idle gaps.
        for (int i = 0; i < 10; i++) begin
            b   = DW'($urandom);
            gap = $urandom_range(0, 20);
            send_frame(b, 1'b1);
            exp_q.push_back(b);
            rises_exp++;
            sig = 1'b1;
            repeat (gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        chk("total_rises", 32'(rise_cnt), 32'(rises_exp));
        chk("total_ferr", 32'(ferr_cnt), 32'(ferr_exp));
        chk("total_ovr", 32'(ovr_cnt), 32'(ovr_exp));
        chk("word_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
